// File: rtl/prep_serializer_pkg.sv
// rtl/prep_serializer_pkg.sv - state encoding and sizing helpers for the config serializer
package prep_serializer_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SEND   = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int padded_width(input int reg_width, input int word_width);
    return ceil_div(reg_width, word_width) * word_width;
  endfunction

endpackage

// File: rtl/cfg_word_shifter.sv
// rtl/cfg_word_shifter.sv - zero-padded snapshot register that presents one word at a time
module cfg_word_shifter
  import prep_serializer_pkg::*;
#(
  parameter int REG_WIDTH  = 1544,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst_N,
  input  logic                  Load_In,
  input  logic                  Shift_In,
  input  logic                  Msb_First_In,
  input  logic [REG_WIDTH-1:0]  In_Register,
  output logic [WORD_WIDTH-1:0] Out_Word
);

  localparam int PAD_WIDTH = padded_width(REG_WIDTH, WORD_WIDTH);
  localparam int PAD_BITS  = PAD_WIDTH - REG_WIDTH;

  logic [PAD_WIDTH-1:0] shift_reg;
  logic                 msb_first;

  // MSB-first puts the padding at the low end so the last word is low bits then zeros
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      shift_reg <= '0;
      msb_first <= 1'b0;
    end else if (Load_In) begin
      msb_first <= Msb_First_In;
      if (Msb_First_In) shift_reg <= PAD_WIDTH'(In_Register) << PAD_BITS;
      else              shift_reg <= PAD_WIDTH'(In_Register);
    end else if (Shift_In) begin
      if (msb_first) shift_reg <= shift_reg << WORD_WIDTH;
      else           shift_reg <= shift_reg >> WORD_WIDTH;
    end
  end

  assign Out_Word = msb_first ? shift_reg[PAD_WIDTH-1 -: WORD_WIDTH] : shift_reg[WORD_WIDTH-1:0];

endmodule

// File: rtl/prep_config_serializer.sv
// rtl/prep_config_serializer.sv - serializes a wide config register into FIFO words; PARITY_WORD_EN adds an XOR check word
module prep_config_serializer
  import prep_serializer_pkg::*;
#(
  parameter int REG_WIDTH  = 1544,
  parameter int WORD_WIDTH = 8,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  Clk,
  input  logic                  Rst_N,
  input  logic                  Start_In,
  input  logic                  Abort_In,
  input  logic                  Msb_First_In,
  input  logic [REG_WIDTH-1:0]  In_Register,
  input  logic                  In_Fifo_Full,
  output logic                  Out_Fifo_Wr_En,
  output logic [WORD_WIDTH-1:0] Out_Fifo_Din,
  output logic                  Out_Busy,
  output logic [CNT_WIDTH-1:0]  Out_Word_Cnt,
  output logic                  End_Flag
);

  localparam int                   NUM_WORDS = ceil_div(REG_WIDTH, WORD_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(NUM_WORDS - 1);

  logic [2:0]            state;
  logic                  start_d;
  logic                  sh_load;
  logic                  sh_shift;
  logic [WORD_WIDTH-1:0] cur_word;
  logic                  start_rise;
  logic                  last_word;
`ifdef PARITY_WORD_EN
  logic [WORD_WIDTH-1:0] parity;
`endif

  assign start_rise = Start_In & ~start_d;
  assign last_word  = (Out_Word_Cnt == LAST_CNT);
  assign sh_load    = (state == LOAD) & ~Abort_In;
  assign sh_shift   = (state == SEND) & ~Abort_In & ~In_Fifo_Full;
  assign Out_Busy   = (state != IDLE);

  cfg_word_shifter #(
    .REG_WIDTH  (REG_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_shifter (
    .Clk          (Clk),
    .Rst_N        (Rst_N),
    .Load_In      (sh_load),
    .Shift_In     (sh_shift),
    .Msb_First_In (Msb_First_In),
    .In_Register  (In_Register),
    .Out_Word     (cur_word)
  );

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state          <= IDLE;
      start_d        <= 1'b0;
      Out_Fifo_Wr_En <= 1'b0;
      Out_Fifo_Din   <= '0;
      Out_Word_Cnt   <= '0;
      End_Flag       <= 1'b0;
`ifdef PARITY_WORD_EN
      parity         <= '0;
`endif
    end else begin
      // edge detector runs in every state so a held Start cannot retrigger
      start_d        <= Start_In;
      Out_Fifo_Wr_En <= 1'b0;
      End_Flag       <= 1'b0;
      if (state != IDLE && Abort_In) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            Out_Fifo_Din <= '0;
            if (start_rise) state <= LOAD;
          end
          LOAD: begin
            Out_Word_Cnt <= '0;
`ifdef PARITY_WORD_EN
            parity       <= '0;
`endif
            state        <= SEND;
          end
          SEND: begin
            if (!In_Fifo_Full) begin
              Out_Fifo_Wr_En <= 1'b1;
              Out_Fifo_Din   <= cur_word;
              Out_Word_Cnt   <= Out_Word_Cnt + CNT_WIDTH'(1);
`ifdef PARITY_WORD_EN
              parity         <= parity ^ cur_word;
              if (last_word) state <= CHECK;
`else
              if (last_word) state <= FINISH;
`endif
            end
          end
`ifdef PARITY_WORD_EN
          CHECK: begin
            if (!In_Fifo_Full) begin
              Out_Fifo_Wr_En <= 1'b1;
              Out_Fifo_Din   <= parity;
              Out_Word_Cnt   <= Out_Word_Cnt + CNT_WIDTH'(1);
              state          <= FINISH;
            end
          end
`endif
          FINISH: begin
            End_Flag <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prep_config_serializer.sv
// tb/tb_prep_config_serializer.sv - randomized self-checking bench for prep_config_serializer
module tb_prep_config_serializer;

  localparam int NW_S = 3;
  localparam int NW_L = 193;
`ifdef PARITY_WORD_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Rst_N;

  logic        s_start, s_abort, s_msb, s_full;
  logic [19:0] s_reg;
  logic        s_wr, s_busy, s_end;
  logic [7:0]  s_din;
  logic [11:0] s_cnt;

  logic          l_start, l_abort, l_msb, l_full;
  logic [1543:0] l_reg;
  logic          l_wr, l_busy, l_end;
  logic [7:0]    l_din;
  logic [11:0]   l_cnt;

  prep_config_serializer #(.REG_WIDTH(20), .WORD_WIDTH(8), .CNT_WIDTH(12)) u_small (
    .Clk(Clk), .Rst_N(Rst_N), .Start_In(s_start), .Abort_In(s_abort), .Msb_First_In(s_msb),
    .In_Register(s_reg), .In_Fifo_Full(s_full), .Out_Fifo_Wr_En(s_wr), .Out_Fifo_Din(s_din),
    .Out_Busy(s_busy), .Out_Word_Cnt(s_cnt), .End_Flag(s_end));

  prep_config_serializer #(.REG_WIDTH(1544), .WORD_WIDTH(8), .CNT_WIDTH(12)) u_large (
    .Clk(Clk), .Rst_N(Rst_N), .Start_In(l_start), .Abort_In(l_abort), .Msb_First_In(l_msb),
    .In_Register(l_reg), .In_Fifo_Full(l_full), .Out_Fifo_Wr_En(l_wr), .Out_Fifo_Din(l_din),
    .Out_Busy(l_busy), .Out_Word_Cnt(l_cnt), .End_Flag(l_end));

  logic [7:0] s_q[$], l_q[$], exp_q[$];
  int s_wc[$], l_wc[$], s_ec[$], l_ec[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    if (s_wr) begin s_q.push_back(s_din); s_wc.push_back(cyc); end
    if (l_wr) begin l_q.push_back(l_din); l_wc.push_back(cyc); end
    if (s_end) s_ec.push_back(cyc);
    if (l_end) l_ec.push_back(cyc);
  endtask

  task automatic clear_obs();
    s_q.delete(); l_q.delete(); s_wc.delete(); l_wc.delete(); s_ec.delete(); l_ec.delete();
  endtask

  // expected word stream from the zero-padding rules, plus XOR word when enabled
  function automatic void build_exp(input logic [1599:0] r, input int rw, input bit msb);
    int nw;
    logic [1599:0] v;
    logic [7:0] p;
    nw = (rw + 7) / 8;
    p = 8'h00;
    exp_q.delete();
    for (int i = 0; i < nw; i++) begin
      if (msb) v = (r << (nw * 8 - rw)) >> ((nw - 1 - i) * 8);
      else     v = r >> (i * 8);
      exp_q.push_back(v[7:0]);
      p = p ^ v[7:0];
    end
    if (NPAR == 1) exp_q.push_back(p);
  endfunction

  function automatic logic [1543:0] rand_big();
    logic [1599:0] t;
    for (int i = 0; i < 50; i++) t[i*32 +: 32] = $urandom;
    return t[1543:0];
  endfunction

  task automatic start_small(input logic [19:0] r, input bit msb);
    s_reg = r; s_msb = msb; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    tick();
    s_reg = 20'($urandom);
  endtask

  task automatic start_large(input logic [1543:0] r, input bit msb);
    l_reg = r; l_msb = msb; l_start = 1'b1;
    tick();
    l_start = 1'b0;
    tick();
    l_reg = rand_big();
  endtask

  task automatic wait_small(input int budget, input bit stall, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (stall) s_full = ($urandom_range(0, 2) == 0);
      tick();
      if (s_ec.size() > 0) begin ok = 1'b1; break; end
    end
    s_full = 1'b0;
  endtask

  task automatic test_reset();
    Rst_N = 1'b0;
    s_start = 0; s_abort = 0; s_msb = 0; s_full = 0; s_reg = '0;
    l_start = 0; l_abort = 0; l_msb = 0; l_full = 0; l_reg = '0;
    #2;
    checks++; if (s_wr !== 1'b0)    begin errors++; $display("FAIL reset_s_wr got=%b exp=0", s_wr); end
    checks++; if (s_din !== 8'h00)  begin errors++; $display("FAIL reset_s_din got=%h exp=00", s_din); end
    checks++; if (s_busy !== 1'b0)  begin errors++; $display("FAIL reset_s_busy got=%b exp=0", s_busy); end
    checks++; if (s_cnt !== 12'd0)  begin errors++; $display("FAIL reset_s_cnt got=%0d exp=0", s_cnt); end
    checks++; if (s_end !== 1'b0)   begin errors++; $display("FAIL reset_s_end got=%b exp=0", s_end); end
    checks++; if (l_wr !== 1'b0)    begin errors++; $display("FAIL reset_l_wr got=%b exp=0", l_wr); end
    checks++; if (l_busy !== 1'b0)  begin errors++; $display("FAIL reset_l_busy got=%b exp=0", l_busy); end
    checks++; if (l_cnt !== 12'd0)  begin errors++; $display("FAIL reset_l_cnt got=%0d exp=0", l_cnt); end
    tick(); tick();
    Rst_N = 1'b1;
    tick();
    clear_obs();
  endtask

  task automatic test_small_known();
    bit ok;
    int start_cyc, bad;
    for (int m = 0; m < 2; m++) begin
      clear_obs();
      exp_q.delete();
      if (m == 0) begin
        exp_q.push_back(8'hAB); exp_q.push_back(8'hCD); exp_q.push_back(8'hE0);
        if (NPAR == 1) exp_q.push_back(8'h86);
      end else begin
        exp_q.push_back(8'hDE); exp_q.push_back(8'hBC); exp_q.push_back(8'h0A);
        if (NPAR == 1) exp_q.push_back(8'h68);
      end
      start_small(20'hABCDE, (m == 0));
      start_cyc = cyc - 1;
      wait_small(40, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL known_timeout mode=%0d got=no_end exp=end", m); end
      bad = -1;
      for (int i = 0; i < exp_q.size(); i++)
        if (bad < 0 && (i >= s_q.size() || s_q[i] !== exp_q[i])) bad = i;
      if (bad < 0 && s_q.size() != exp_q.size()) bad = exp_q.size();
      checks++; if (bad >= 0) begin errors++; $display("FAIL known_words mode=%0d first_bad=%0d got_n=%0d exp_n=%0d", m, bad, s_q.size(), exp_q.size()); end
      checks++; if (s_wc.size() == 0 || s_wc[0] !== start_cyc + 2) begin errors++; $display("FAIL known_latency mode=%0d got_n=%0d exp_first=%0d", m, s_wc.size(), start_cyc + 2); end
      checks++; if (s_wc.size() == 0 || s_wc[s_wc.size()-1] - s_wc[0] !== NW_S + NPAR - 1) begin errors++; $display("FAIL known_consecutive mode=%0d got_n=%0d exp_span=%0d", m, s_wc.size(), NW_S + NPAR - 1); end
      checks++; if (s_ec.size() != 1 || s_wc.size() == 0 || s_ec[0] !== s_wc[s_wc.size()-1] + 1) begin errors++; $display("FAIL known_end_timing mode=%0d got_ends=%0d exp=1_after_last", m, s_ec.size()); end
      checks++; if (s_cnt !== 12'(NW_S + NPAR)) begin errors++; $display("FAIL known_cnt mode=%0d got=%0d exp=%0d", m, s_cnt, NW_S + NPAR); end
      checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL known_busy_end mode=%0d got=%b exp=0", m, s_busy); end
      tick();
      checks++; if (s_din !== 8'h00 || s_wr !== 1'b0) begin errors++; $display("FAIL known_idle_din mode=%0d got=%h/%b exp=00/0", m, s_din, s_wr); end
      checks++; if (s_cnt !== 12'(NW_S + NPAR)) begin errors++; $display("FAIL known_cnt_hold mode=%0d got=%0d exp=%0d", m, s_cnt, NW_S + NPAR); end
    end
  endtask

  task automatic test_small_random();
    bit ok, msb;
    logic [19:0] r;
    logic [1599:0] t;
    int bad;
    for (int n = 0; n < 8; n++) begin
      clear_obs();
      r = 20'($urandom);
      msb = 1'($urandom);
      t = '0; t[19:0] = r;
      build_exp(t, 20, msb);
      start_small(r, msb);
      wait_small(80, 1'b1, ok);
      bad = -1;
      for (int i = 0; i < exp_q.size(); i++)
        if (bad < 0 && (i >= s_q.size() || s_q[i] !== exp_q[i])) bad = i;
      if (bad < 0 && s_q.size() != exp_q.size()) bad = exp_q.size();
      checks++; if (!ok || bad >= 0) begin errors++; $display("FAIL rand_words n=%0d reg=%h msb=%0d ok=%0d first_bad=%0d got_n=%0d exp_n=%0d", n, r, msb, ok, bad, s_q.size(), exp_q.size()); end
      checks++; if (s_cnt !== 12'(NW_S + NPAR)) begin errors++; $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, s_cnt, NW_S + NPAR); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok, stalled, din_bad;
    int stall, bad;
    logic [7:0] held;
    logic [1543:0] r;
    logic [1599:0] t;
    clear_obs();
    r = rand_big();
    t = '0; t[1543:0] = r;
    build_exp(t, 1544, 1'b1);
    start_large(r, 1'b1);
    ok = 0; stalled = 0; din_bad = 0; stall = 0; held = '0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (stall > 0) begin
        if (l_din !== held || l_wr !== 1'b0) din_bad = 1'b1;
        stall--;
        if (stall == 0) l_full = 1'b0;
      end else if (!stalled && l_q.size() == 10) begin
        l_full = 1'b1; stall = 5; stalled = 1'b1; held = l_din;
      end
      if (l_ec.size() > 0) begin ok = 1'b1; break; end
    end
    l_full = 1'b0;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= l_q.size() || l_q[i] !== exp_q[i])) bad = i;
    if (bad < 0 && l_q.size() != exp_q.size()) bad = exp_q.size();
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got=no_end exp=end"); end
    checks++; if (bad >= 0) begin errors++; $display("FAIL bp_words first_bad=%0d got_n=%0d exp_n=%0d", bad, l_q.size(), exp_q.size()); end
    checks++; if (din_bad) begin errors++; $display("FAIL bp_din_stable got=changed exp=%h", held); end
    checks++; if (l_wc.size() == 0 || l_wc[l_wc.size()-1] - l_wc[0] !== NW_L + NPAR - 1 + 5) begin errors++; $display("FAIL bp_span got_n=%0d exp_span=%0d", l_wc.size(), NW_L + NPAR + 4); end
    checks++; if (l_cnt !== 12'(NW_L + NPAR)) begin errors++; $display("FAIL bp_cnt got=%0d exp=%0d", l_cnt, NW_L + NPAR); end
    tick();
  endtask

  task automatic test_abort();
    bit ok;
    int bad;
    logic [1543:0] r;
    logic [1599:0] t;
    clear_obs();
    start_large(rand_big(), 1'b0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (l_q.size() == 50) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL abort_reach50 got=%0d exp=50", l_q.size()); end
    l_abort = 1'b1;
    tick();
    l_abort = 1'b0;
    checks++; if (l_wr !== 1'b0 || l_busy !== 1'b0) begin errors++; $display("FAIL abort_stop got_wr=%b got_busy=%b exp=0/0", l_wr, l_busy); end
    repeat (6) tick();
    checks++; if (l_q.size() != 50 || l_ec.size() != 0) begin errors++; $display("FAIL abort_quiet got_n=%0d got_ends=%0d exp=50/0", l_q.size(), l_ec.size()); end
    checks++; if (l_cnt !== 12'd50) begin errors++; $display("FAIL abort_cnt got=%0d exp=50", l_cnt); end
    clear_obs();
    r = rand_big();
    t = '0; t[1543:0] = r;
    build_exp(t, 1544, 1'b0);
    start_large(r, 1'b0);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (l_ec.size() > 0) begin ok = 1'b1; break; end
    end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= l_q.size() || l_q[i] !== exp_q[i])) bad = i;
    if (bad < 0 && l_q.size() != exp_q.size()) bad = exp_q.size();
    checks++; if (!ok || bad >= 0) begin errors++; $display("FAIL abort_restart ok=%0d first_bad=%0d got_n=%0d exp_n=%0d", ok, bad, l_q.size(), exp_q.size()); end
    checks++; if (l_cnt !== 12'(NW_L + NPAR)) begin errors++; $display("FAIL abort_restart_cnt got=%0d exp=%0d", l_cnt, NW_L + NPAR); end
    tick();
  endtask

  task automatic test_held_start();
    bit dropped;
    clear_obs();
    s_reg = 20'($urandom);
    s_msb = 1'($urandom);
    s_start = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!dropped && s_q.size() == 1) begin
        s_start = 1'b0; dropped = 1'b1;
      end else if (dropped) begin
        s_start = 1'b1;
      end
    end
    checks++; if (s_ec.size() != 1) begin errors++; $display("FAIL held_ends got=%0d exp=1", s_ec.size()); end
    checks++; if (s_q.size() != NW_S + NPAR) begin errors++; $display("FAIL held_writes got=%0d exp=%0d", s_q.size(), NW_S + NPAR); end
    s_start = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_small_known();
    test_small_random();
    test_backpressure();
    test_abort();
    test_held_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
